// File: rtl/id_hazard_pipe.sv
// id_hazard_pipe: ID->EX issue register with valid/ready handshake, an
// in-flight writer tracker and a hazard unit.
// Each source operand gets a one-hot forward select, computed at issue over
// the FWD_DEPTH stages that sit downstream of the consumer. A load-use
// hazard holds the ID stage and injects bubbles until the load data can be
// forwarded.
// Optional feature: define ID_HAZARD_PERF_CNT_EN to add the stall and bubble
// performance counters.
module id_hazard_pipe #(
    parameter int RF_AW     = 5,
    parameter int PAYLOAD_W = 128,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RF_AW-1:0]     in_rs1_addr,
    input  logic                 in_rs1_rd,
    input  logic [RF_AW-1:0]     in_rs2_addr,
    input  logic                 in_rs2_rd,
    input  logic [RF_AW-1:0]     in_rd,
    input  logic                 in_wen,
    input  logic                 in_is_load,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RF_AW-1:0]     out_rd,
    output logic                 out_wen,
    output logic                 out_is_load,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [FWD_DEPTH-1:0] out_fwd1_sel,
    output logic [FWD_DEPTH-1:0] out_fwd2_sel,
    output logic                 load_stall
`ifdef ID_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt
`endif
);

    localparam int TRK_N = FWD_DEPTH - 1;

    // Tracker entries: the writers that have already left the out register
    // but have not yet reached the regfile.
    logic [TRK_N-1:0]     trk_v_reg;
    logic [TRK_N-1:0]     trk_wen_reg;
    logic [TRK_N-1:0]     trk_ld_reg;
    logic [RF_AW-1:0]     trk_rd_reg [TRK_N];

    // Forward sources, seen from the point where the consumer enters EX.
    // Index 0 is the out register. Index k is tracker[k-1].
    logic [FWD_DEPTH-1:0] src_v;
    logic [FWD_DEPTH-1:0] src_wen;
    logic [FWD_DEPTH-1:0] src_ld;
    logic [RF_AW-1:0]     src_rd [FWD_DEPTH];
    logic [FWD_DEPTH-1:0] lat_mask;
    logic [FWD_DEPTH-1:0] match1;
    logic [FWD_DEPTH-1:0] match2;
    logic [FWD_DEPTH-1:0] sel1_next;
    logic [FWD_DEPTH-1:0] sel2_next;
    logic                 issue;

    assign src_v[0]   = out_valid;
    assign src_wen[0] = out_wen;
    assign src_ld[0]  = out_is_load;
    assign src_rd[0]  = out_rd;

    genvar gi;
    generate
        for (gi = 1; gi < FWD_DEPTH; gi++) begin : g_src
            assign src_v[gi]   = trk_v_reg[gi-1];
            assign src_wen[gi] = trk_wen_reg[gi-1];
            assign src_ld[gi]  = trk_ld_reg[gi-1];
            assign src_rd[gi]  = trk_rd_reg[gi-1];
        end
        for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
            // A load in a stage younger than LOAD_LAT has no data to forward yet.
            assign lat_mask[gi] = (gi < LOAD_LAT);
            assign match1[gi] = src_v[gi] & src_wen[gi] & (src_rd[gi] != '0) &
                                (src_rd[gi] == in_rs1_addr) & in_rs1_rd;
            assign match2[gi] = src_v[gi] & src_wen[gi] & (src_rd[gi] != '0) &
                                (src_rd[gi] == in_rs2_addr) & in_rs2_rd;
        end
    endgenerate

    // Priority pick. The scan runs from oldest to youngest, so the youngest
    // match is the one that remains in the select.
    always_comb begin
        sel1_next = '0;
        sel2_next = '0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (match1[i]) begin
                sel1_next    = '0;
                sel1_next[i] = 1'b1;
            end
            if (match2[i]) begin
                sel2_next    = '0;
                sel2_next[i] = 1'b1;
            end
        end
    end

    assign load_stall = in_valid & ~flush &
                        ((|(sel1_next & src_ld & lat_mask)) |
                         (|(sel2_next & src_ld & lat_mask)));
    assign in_ready   = ~load_stall & ~flush & (~out_valid | out_ready);
    assign issue      = in_valid & in_ready;

    // Tracker shift. It advances only when EX accepts. Flush leaves it
    // untouched because the older producers still commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk_v_reg   <= '0;
            trk_wen_reg <= '0;
            trk_ld_reg  <= '0;
            for (int i = 0; i < TRK_N; i++) trk_rd_reg[i] <= '0;
        end else if (out_ready) begin
            for (int i = 0; i < TRK_N; i++) begin
                trk_v_reg[i]   <= src_v[i];
                trk_wen_reg[i] <= src_wen[i];
                trk_ld_reg[i]  <= src_ld[i];
                trk_rd_reg[i]  <= src_rd[i];
            end
        end
    end

    // EX-entry register. Priority order: flush, then issue, then bubble on
    // drain, then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_wen      <= 1'b0;
            out_is_load  <= 1'b0;
            out_payload  <= '0;
            out_fwd1_sel <= '0;
            out_fwd2_sel <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_rd       <= in_rd;
            out_wen      <= in_wen;
            out_is_load  <= in_is_load;
            out_payload  <= in_payload;
            out_fwd1_sel <= sel1_next;
            out_fwd2_sel <= sel2_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_HAZARD_PERF_CNT_EN
    // Count load-use stall cycles, and the bubbles that replace a valid
    // instruction as it drains out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (load_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (out_ready && out_valid && !issue && !flush)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
